imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: byte address that word 0 is written to.
REQ-002 Parameter MAX_WORDS, default 16384: largest accepted program length, in words.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle pulse that begins a program load.
REQ-006 s_valid  input  1  byte-stream data valid.
REQ-007 s_data  input  8  byte-stream payload.
REQ-008 s_ready  output  1  loader accepts a byte; a transfer occurs when s_valid and s_ready are both 1 on a rising edge.
REQ-009 im_w_en  output  4  instruction-SRAM byte write enables.
REQ-010 im_addr  output  32  instruction-SRAM byte address.
REQ-011 im_wdata  output  32  instruction-SRAM write data.
REQ-012 cpu_hold  output  1  1 = hold the CPU core in reset.
REQ-013 done  output  1  load completed successfully.
REQ-014 err  output  1  load aborted because the length was illegal.
REQ-015 word_cnt  output  16  number of words written in the current load.

Function
REQ-016 Stream format: LEN_LO byte, then LEN_HI byte (N = 16-bit little-endian word count), then 4*N data bytes, each word sent little-endian (first byte goes to [7:0]).
REQ-017 FSM states: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR.
REQ-018 IDLE, DONE or ERR, on start=1: go to LEN_LO, clear word_cnt, done and err, and set cpu_hold=1.
REQ-019 s_ready = 1 only in LEN_LO, LEN_HI and DATA; s_ready = 0 in every other state.
REQ-020 Transfer in LEN_LO: latch the low length byte, go to LEN_HI.
REQ-021 Transfer in LEN_HI: if N=0, go to DONE; if N>MAX_WORDS, go to ERR; otherwise go to DATA.
REQ-022 DATA: shift each accepted byte into a 32-bit assembly register and count bytes 0..3; the 4th byte moves the FSM to WRITE on the same edge.
REQ-023 WRITE lasts exactly one cycle with im_w_en=4'b1111, im_addr=BASE_ADDR+4*word_cnt and im_wdata = the assembled word.
REQ-024 Leaving WRITE: increment word_cnt; go to DONE if the new word_cnt equals N, otherwise return to DATA.
REQ-025 im_w_en = 4'b0000 in every state except WRITE.
REQ-026 Maximum throughput: 4 bytes per 5 cycles.
REQ-027 DONE: done=1 and cpu_hold=0, both held until the next start.
REQ-028 ERR: err=1 and cpu_hold=1, both held until the next start.
REQ-029 start is ignored in LEN_LO, LEN_HI, DATA and WRITE.
REQ-030 s_valid=0 in a receiving state causes a stall with no state change; there is no timeout.
REQ-031 The byte counter wraps 3->0 on each completed word; word_cnt never exceeds N.
REQ-032 The loader never writes past BASE_ADDR+4*(MAX_WORDS-1).

Reset
REQ-033 rst=0 immediately forces, asynchronously: state=IDLE, cpu_hold=1, done=0, err=0, im_w_en=0, im_addr=BASE_ADDR, im_wdata=0, word_cnt=0, s_ready=0.
REQ-034 Reset asserted mid-load aborts the load; it issues no partial write and does not resume.
REQ-035 After rst deasserts, the loader stays in IDLE with cpu_hold=1 until start.

Structure
REQ-036 The FSM state enum and the IM_WORD_BYTES=4 constant shall live in the shared package define.sv.
REQ-037 There is one sub-module, byte_packer: 8-to-32 little-endian assembly with a 2-bit counter and a word_valid output.
REQ-038 im_w_en, im_addr and im_wdata drive the instruction-SRAM write port; cpu_hold drives the core's PC/regfile reset.

Verification
REQ-039 Reset, then start, then stream 02 00 13 00 00 00 93 00 10 00 -> writes 0x00000013 @0x0 then 0x00100093 @0x4; done=1, cpu_hold=0, word_cnt=2.
REQ-040 Start, then stream 00 00 -> DONE with no writes; done=1, cpu_hold=0.
REQ-041 MAX_WORDS=4, start, then stream 05 00 -> err=1, cpu_hold=1, no writes; s_ready=0 afterwards.
REQ-042 N=1 with s_valid toggled 1/0 every cycle -> a single write of the correct word; no byte lost or duplicated.
REQ-043 Assert rst after the 6th byte of an N=2 load -> exactly one write seen (word 0); outputs at reset values; a fresh start reloads correctly.
REQ-044 Pulse start during DATA -> ignored; the load completes normally.

Source files
------------

// File: rtl/define.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and the SRAM word geometry.
package imem_loader_pkg;

    localparam int IM_WORD_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian 8-to-32 assembler. The first byte of a word lands in [7:0].
// word_vld_o fires combinationally with the 4th byte so the caller can
// capture the complete word on the same edge that accepts that byte.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_i,
    output logic        word_vld_o,
    output logic [31:0] word_o
);

    logic [1:0]  cnt_q;
    logic [23:0] sh_q;

    // Only the three earlier bytes need storage; the 4th is still on byte_i.
    assign word_o     = {byte_i, sh_q};
    assign word_vld_o = byte_vld_i && (cnt_q == 2'd3);

    // Shift bytes in from the top and count 0..3, wrapping on each word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 2'd0;
            sh_q  <= 24'h0;
        end else if (clr_i) begin
            cnt_q <= 2'd0;
            sh_q  <= 24'h0;
        end else if (byte_vld_i) begin
            cnt_q <= cnt_q + 2'd1;
            sh_q  <= {byte_i, sh_q[23:8]};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader: receives a length-prefixed byte stream and
// writes it word by word into the instruction SRAM while holding the core
// in reset. Releases the core only after a complete, legal load.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic [3:0]  im_w_en,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err,
    output logic [15:0] word_cnt
);

    state_e      state_q;
    logic        s_ready_q;
    logic [3:0]  im_w_en_q;
    logic [31:0] im_addr_q;
    logic [31:0] im_wdata_q;
    logic        cpu_hold_q;
    logic        done_q;
    logic        err_q;
    logic [15:0] word_cnt_q;
    logic [15:0] n_q;
    logic [7:0]  len_lo_q;

    logic        idle_like;
    logic        xfer;
    logic [15:0] len_w;
    logic [15:0] cnt_inc;
    logic        pk_vld;
    logic [31:0] pk_word;

    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR);
    assign xfer      = s_valid && s_ready_q;
    assign len_w     = {s_data, len_lo_q};
    assign cnt_inc   = word_cnt_q + 16'd1;

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (start && idle_like),
        .byte_vld_i (xfer && (state_q == ST_DATA)),
        .byte_i     (s_data),
        .word_vld_o (pk_vld),
        .word_o     (pk_word)
    );

    // Load sequencer; every output is a register updated alongside the state.
    // Because N is capped at MAX_WORDS and word_cnt stops at N, the highest
    // address ever written is BASE_ADDR + 4*(MAX_WORDS-1).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            s_ready_q  <= 1'b0;
            im_w_en_q  <= 4'b0000;
            im_addr_q  <= BASE_ADDR;
            im_wdata_q <= 32'h0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            word_cnt_q <= 16'h0;
            n_q        <= 16'h0;
            len_lo_q   <= 8'h0;
        end else begin
            im_w_en_q <= 4'b0000;
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state_q    <= ST_LEN_LO;
                        s_ready_q  <= 1'b1;
                        word_cnt_q <= 16'h0;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        cpu_hold_q <= 1'b1;
                    end
                end
                ST_LEN_LO: begin
                    if (xfer) begin
                        len_lo_q <= s_data;
                        state_q  <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (xfer) begin
                        n_q <= len_w;
                        if (len_w == 16'h0) begin
                            state_q    <= ST_DONE;
                            s_ready_q  <= 1'b0;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else if (32'(len_w) > 32'(MAX_WORDS)) begin
                            state_q   <= ST_ERR;
                            s_ready_q <= 1'b0;
                            err_q     <= 1'b1;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (pk_vld) begin
                        state_q    <= ST_WRITE;
                        s_ready_q  <= 1'b0;
                        im_w_en_q  <= 4'b1111;
                        im_addr_q  <= BASE_ADDR + 32'(word_cnt_q) * 32'(IM_WORD_BYTES);
                        im_wdata_q <= pk_word;
                    end
                end
                ST_WRITE: begin
                    word_cnt_q <= cnt_inc;
                    if (cnt_inc == n_q) begin
                        state_q    <= ST_DONE;
                        done_q     <= 1'b1;
                        cpu_hold_q <= 1'b0;
                    end else begin
                        state_q   <= ST_DATA;
                        s_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    s_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready  = s_ready_q;
    assign im_w_en  = im_w_en_q;
    assign im_addr  = im_addr_q;
    assign im_wdata = im_wdata_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign err      = err_q;
    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (MAX_WORDS=4 so the length limit is cheap
// to reach). A monitor logs every SRAM write; scenario tasks compare that
// log and the status outputs against hand-computed values.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h0;
    logic        s_ready;
    logic [3:0]  im_w_en;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [15:0] word_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    int          cyc = 0;
    logic [7:0]  stim[$];

    imem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .im_w_en  (im_w_en),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    // Write-port monitor: each enabled cycle is one SRAM write.
    always @(posedge clk) begin
        if (im_w_en != 4'b0000) begin
            checks++;
            if (im_w_en !== 4'b1111) begin
                errors++;
                $display("FAIL w_en_pattern: got %b want 1111", im_w_en);
            end
            wr_addr.push_back(im_addr);
            wr_data.push_back(im_wdata);
            wr_cyc.push_back(cyc);
        end
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // All helper tasks start and end just after a falling edge.
    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        s_valid = 1'b1;
        s_data  = b;
        while (s_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (s_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout: byte %h never accepted", b);
        end else begin
            @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    task automatic send_stim(input bit gap);
        foreach (stim[i]) begin
            send_byte(stim[i]);
            if (gap) @(negedge clk);
        end
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(done === 1'b1 || err === 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!(done === 1'b1 || err === 1'b1)) begin
            checks++;
            errors++;
            $display("FAIL wait_end_timeout: done=%b err=%b", done, err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL rst_cpu_hold: got %b want 1", cpu_hold); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
        checks++; if (im_w_en !== 4'b0) begin errors++; $display("FAIL rst_w_en: got %b want 0000", im_w_en); end
        checks++; if (im_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 00000000", im_addr); end
        checks++; if (im_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h want 00000000", im_wdata); end
        checks++; if (word_cnt !== 16'h0) begin errors++; $display("FAIL rst_word_cnt: got %0d want 0", word_cnt); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        s_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL idle_s_ready: got %b want 0", s_ready); end
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL idle_cpu_hold: got %b want 1", cpu_hold); end
        s_valid = 1'b0;
    endtask

    task automatic test_load_two();
        clear_log();
        do_start();
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL start_s_ready: got %b want 1", s_ready); end
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL start_cpu_hold: got %b want 1", cpu_hold); end
        stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        send_stim(1'b0);
        wait_end();
        checks++;
        if (wr_addr.size() != 2) begin
            errors++; $display("FAIL two_write_count: got %0d want 2", wr_addr.size());
        end else begin
            if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h0000_0013) begin
                errors++; $display("FAIL two_word0: got %h@%h want 00000013@00000000", wr_data[0], wr_addr[0]);
            end
            checks++;
            if (wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h0010_0093) begin
                errors++; $display("FAIL two_word1: got %h@%h want 00100093@00000004", wr_data[1], wr_addr[1]);
            end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL two_done: got %b want 1", done); end
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL two_cpu_hold: got %b want 0", cpu_hold); end
        checks++; if (word_cnt !== 16'd2) begin errors++; $display("FAIL two_word_cnt: got %0d want 2", word_cnt); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL two_s_ready: got %b want 0", s_ready); end
    endtask

    task automatic test_zero_len();
        clear_log();
        do_start();
        stim = '{8'h00, 8'h00};
        send_stim(1'b0);
        wait_end();
        repeat (2) @(negedge clk);
        checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL zero_writes: got %0d want 0", wr_addr.size()); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", done); end
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL zero_cpu_hold: got %b want 0", cpu_hold); end
        checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL zero_word_cnt: got %0d want 0", word_cnt); end
    endtask

    task automatic test_too_long();
        clear_log();
        do_start();
        stim = '{8'h05, 8'h00};
        send_stim(1'b0);
        wait_end();
        s_valid = 1'b1;
        s_data  = 8'hAA;
        repeat (3) @(negedge clk);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL long_err: got %b want 1", err); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL long_done: got %b want 0", done); end
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL long_cpu_hold: got %b want 1", cpu_hold); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL long_s_ready: got %b want 0", s_ready); end
        checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL long_writes: got %0d want 0", wr_addr.size()); end
        s_valid = 1'b0;
    endtask

    task automatic test_max_len();
        clear_log();
        do_start();
        stim = '{8'h04, 8'h00,
                 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                 8'h08, 8'h09, 8'h0a, 8'h0b, 8'h0c, 8'h0d, 8'h0e, 8'h0f};
        send_stim(1'b0);
        wait_end();
        checks++;
        if (wr_addr.size() != 4) begin
            errors++; $display("FAIL max_write_count: got %0d want 4", wr_addr.size());
        end else begin
            if (wr_data[0] !== 32'h0302_0100) begin
                errors++; $display("FAIL max_word0: got %h want 03020100", wr_data[0]);
            end
            checks++;
            if (wr_addr[3] !== 32'hC || wr_data[3] !== 32'h0f0e_0d0c) begin
                errors++; $display("FAIL max_word3: got %h@%h want 0f0e0d0c@0000000c", wr_data[3], wr_addr[3]);
            end
            checks++;
            if (wr_cyc[1] - wr_cyc[0] != 5) begin
                errors++; $display("FAIL max_throughput: got %0d cycles want 5", wr_cyc[1] - wr_cyc[0]);
            end
        end
        checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL max_status: got done=%b err=%b want done=1 err=0", done, err); end
        checks++; if (word_cnt !== 16'd4) begin errors++; $display("FAIL max_word_cnt: got %0d want 4", word_cnt); end
    endtask

    task automatic test_valid_toggle();
        clear_log();
        do_start();
        stim = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_stim(1'b1);
        wait_end();
        checks++;
        if (wr_addr.size() != 1) begin
            errors++; $display("FAIL toggle_write_count: got %0d want 1", wr_addr.size());
        end else if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL toggle_word: got %h@%h want deadbeef@00000000", wr_data[0], wr_addr[0]);
        end
        checks++; if (word_cnt !== 16'd1 || done !== 1'b1) begin errors++; $display("FAIL toggle_status: got cnt=%0d done=%b want cnt=1 done=1", word_cnt, done); end
    endtask

    task automatic test_reset_midload();
        clear_log();
        do_start();
        stim = '{8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
        send_stim(1'b0);
        @(negedge clk);
        send_byte(8'h55);
        rst = 1'b0;
        #1;
        checks++;
        if (wr_addr.size() != 1) begin
            errors++; $display("FAIL midrst_write_count: got %0d want 1", wr_addr.size());
        end else if (wr_data[0] !== 32'h1122_3344) begin
            errors++; $display("FAIL midrst_word0: got %h want 11223344", wr_data[0]);
        end
        checks++; if (cpu_hold !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL midrst_status: got hold=%b done=%b err=%b want 1 0 0", cpu_hold, done, err); end
        checks++; if (im_w_en !== 4'b0 || im_wdata !== 32'h0 || im_addr !== 32'h0) begin errors++; $display("FAIL midrst_port: got en=%b d=%h a=%h want 0", im_w_en, im_wdata, im_addr); end
        checks++; if (word_cnt !== 16'd0 || s_ready !== 1'b0) begin errors++; $display("FAIL midrst_cnt_ready: got cnt=%0d rdy=%b want 0 0", word_cnt, s_ready); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h66;
        repeat (4) @(negedge clk);
        s_valid = 1'b0;
        checks++; if (wr_addr.size() != 1 || s_ready !== 1'b0 || cpu_hold !== 1'b1) begin errors++; $display("FAIL midrst_no_resume: got writes=%0d rdy=%b hold=%b want 1 0 1", wr_addr.size(), s_ready, cpu_hold); end
        clear_log();
        do_start();
        stim = '{8'h02, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
        send_stim(1'b0);
        wait_end();
        checks++;
        if (wr_addr.size() != 2) begin
            errors++; $display("FAIL reload_write_count: got %0d want 2", wr_addr.size());
        end else if (wr_data[0] !== 32'hA4A3_A2A1 || wr_addr[1] !== 32'h4 || wr_data[1] !== 32'hB4B3_B2B1) begin
            errors++; $display("FAIL reload_words: got %h %h@%h want a4a3a2a1 b4b3b2b1@00000004", wr_data[0], wr_data[1], wr_addr[1]);
        end
        checks++; if (done !== 1'b1 || word_cnt !== 16'd2) begin errors++; $display("FAIL reload_status: got done=%b cnt=%0d want 1 2", done, word_cnt); end
    endtask

    task automatic test_start_ignored();
        clear_log();
        do_start();
        stim = '{8'h02, 8'h00, 8'hC0};
        send_stim(1'b0);
        do_start();
        checks++; if (s_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL ign_mid_state: got rdy=%b done=%b want 1 0", s_ready, done); end
        stim = '{8'hC1, 8'hC2, 8'hC3, 8'hD0, 8'hD1, 8'hD2, 8'hD3};
        send_stim(1'b0);
        wait_end();
        checks++;
        if (wr_addr.size() != 2) begin
            errors++; $display("FAIL ign_write_count: got %0d want 2", wr_addr.size());
        end else if (wr_data[0] !== 32'hC3C2_C1C0 || wr_data[1] !== 32'hD3D2_D1D0 || wr_addr[1] !== 32'h4) begin
            errors++; $display("FAIL ign_words: got %h %h@%h want c3c2c1c0 d3d2d1d0@00000004", wr_data[0], wr_data[1], wr_addr[1]);
        end
        checks++; if (done !== 1'b1 || word_cnt !== 16'd2 || cpu_hold !== 1'b0) begin errors++; $display("FAIL ign_status: got done=%b cnt=%0d hold=%b want 1 2 0", done, word_cnt, cpu_hold); end
    endtask

    initial begin
        #2;
        test_reset();
        test_load_two();
        test_zero_len();
        test_too_long();
        test_max_len();
        test_valid_toggle();
        test_reset_midload();
        test_start_ignored();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
